// File: rtl/noc_ps_mux.sv
// Packet-switched NoC multiplexer: per-channel FIFOs, round-robin packet-atomic
// arbitration onto a registered NoC output, plus a registered inbound pass-through.
module noc_ps_mux #(
  parameter int unsigned NCH   = 4,
  parameter int unsigned DW    = 8,
  parameter int unsigned DEPTH = 4
) (
  input  logic              clk,
  input  logic              reset,
  input  logic [NCH-1:0]    ch_valid,
  output logic [NCH-1:0]    ch_ready,
  input  logic [NCH*DW-1:0] ch_data,
  input  logic [NCH-1:0]    ch_last,
  input  logic              noc_stall,
  output logic              noc_from_dev_ctl,
  output logic [DW-1:0]     noc_from_dev_data,
  output logic              noc_from_dev_last,
  input  logic              noc_to_dev_ctl,
  input  logic [DW-1:0]     noc_to_dev_data,
  output logic              dev_ctl_out,
  output logic [DW-1:0]     dev_data_out
);

  localparam int unsigned CW   = $clog2(NCH);
  localparam int unsigned PW   = $clog2(DEPTH);
  localparam int unsigned CNTW = PW + 1;

  typedef enum logic [1:0] {IDLE, HDR, BODY} state_e;

  logic [DW:0]     mem_q  [NCH][DEPTH];
  logic [PW-1:0]   wptr_q [NCH];
  logic [PW-1:0]   wptr_d [NCH];
  logic [PW-1:0]   rptr_q [NCH];
  logic [PW-1:0]   rptr_d [NCH];
  logic [CNTW-1:0] cnt_q  [NCH];
  logic [CNTW-1:0] cnt_d  [NCH];
  logic [DW:0]     head   [NCH];
  logic [NCH-1:0]  push;
  logic [NCH-1:0]  pop;
  logic [NCH-1:0]  nempty;

  state_e          state_q, state_d;
  logic [CW-1:0]   grant_q, grant_d;
  logic [CW-1:0]   rr_q, rr_d;
  logic            ctl_q, ctl_d;
  logic [DW-1:0]   data_q, data_d;
  logic            last_q, last_d;
  logic            dev_ctl_q;
  logic [DW-1:0]   dev_data_q;

  logic            found;
  logic [CW-1:0]   sel;
  logic [DW-1:0]   hdr;
  int unsigned     idx;

  // FIFO status comes from registered counts only, so ready never sees pops.
  always_comb begin
    for (int unsigned i = 0; i < NCH; i++) begin
      ch_ready[i] = (cnt_q[i] != CNTW'(DEPTH));
      nempty[i]   = (cnt_q[i] != '0);
      push[i]     = ch_valid[i] && ch_ready[i];
      head[i]     = mem_q[i][rptr_q[i]];
    end
  end

  always_comb begin
    for (int unsigned i = 0; i < NCH; i++) begin
      wptr_d[i] = push[i] ? wptr_q[i] + PW'(1) : wptr_q[i];
      rptr_d[i] = pop[i]  ? rptr_q[i] + PW'(1) : rptr_q[i];
      cnt_d[i]  = cnt_q[i];
      if (push[i] && !pop[i]) begin
        cnt_d[i] = cnt_q[i] + CNTW'(1);
      end else if (!push[i] && pop[i]) begin
        cnt_d[i] = cnt_q[i] - CNTW'(1);
      end
    end
  end

  always_ff @(posedge clk) begin
    for (int unsigned i = 0; i < NCH; i++) begin
      if (push[i]) begin
        mem_q[i][wptr_q[i]] <= {ch_last[i], ch_data[i*DW +: DW]};
      end
    end
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      for (int unsigned i = 0; i < NCH; i++) begin
        wptr_q[i] <= '0;
        rptr_q[i] <= '0;
        cnt_q[i]  <= '0;
      end
    end else begin
      for (int unsigned i = 0; i < NCH; i++) begin
        wptr_q[i] <= wptr_d[i];
        rptr_q[i] <= rptr_d[i];
        cnt_q[i]  <= cnt_d[i];
      end
    end
  end

  always_comb begin
    found = 1'b0;
    sel   = '0;
    idx   = 0;
    for (int unsigned k = 0; k < NCH; k++) begin
      idx = int'(rr_q) + k;
      if (idx >= NCH) idx = idx - NCH;
      if (!found && nempty[idx]) begin
        found = 1'b1;
        sel   = CW'(idx);
      end
    end
    hdr          = '0;
    hdr[DW-1]    = 1'b1;
    hdr[CW-1:0]  = sel;
  end

  always_comb begin
    state_d = state_q;
    grant_d = grant_q;
    rr_d    = rr_q;
    ctl_d   = ctl_q;
    data_d  = data_q;
    last_d  = last_q;
    pop     = '0;
    if (!noc_stall) begin
      case (state_q)
        IDLE: begin
          ctl_d  = 1'b1;
          last_d = 1'b0;
          data_d = '0;
          if (found) begin
            grant_d = sel;
            data_d  = hdr;
            state_d = HDR;
          end
        end
        HDR, BODY: begin
          // The last flit is on the output; leaving now means it was accepted.
          if (state_q == BODY && last_q) begin
            state_d = IDLE;
            rr_d    = (grant_q == CW'(NCH - 1)) ? '0 : grant_q + CW'(1);
            ctl_d   = 1'b1;
            data_d  = '0;
            last_d  = 1'b0;
          end else begin
            state_d = BODY;
            if (nempty[grant_q]) begin
              pop[grant_q]     = 1'b1;
              ctl_d            = 1'b0;
              {last_d, data_d} = head[grant_q];
            end else begin
              ctl_d  = 1'b1;
              data_d = '0;
              last_d = 1'b0;
            end
          end
        end
        default: state_d = IDLE;
      endcase
    end
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      state_q    <= IDLE;
      grant_q    <= '0;
      rr_q       <= '0;
      ctl_q      <= 1'b1;
      data_q     <= '0;
      last_q     <= 1'b0;
      dev_ctl_q  <= 1'b1;
      dev_data_q <= '0;
    end else begin
      state_q    <= state_d;
      grant_q    <= grant_d;
      rr_q       <= rr_d;
      ctl_q      <= ctl_d;
      data_q     <= data_d;
      last_q     <= last_d;
      dev_ctl_q  <= noc_to_dev_ctl;
      dev_data_q <= noc_to_dev_data;
    end
  end

  assign noc_from_dev_ctl  = ctl_q;
  assign noc_from_dev_data = data_q;
  assign noc_from_dev_last = last_q;
  assign dev_ctl_out       = dev_ctl_q;
  assign dev_data_out      = dev_data_q;

endmodule

// File: tb/tb_noc_ps_mux.sv
// Bench for noc_ps_mux: directed scenarios plus randomized traffic, all checked
// against a queue-based packet model of the mux.
module tb_noc_ps_mux;

  localparam int NCH   = 4;
  localparam int DW    = 8;
  localparam int DEPTH = 4;

  logic              clk = 1'b0;
  logic              reset;
  logic [NCH-1:0]    ch_valid;
  logic [NCH-1:0]    ch_ready;
  logic [NCH*DW-1:0] ch_data;
  logic [NCH-1:0]    ch_last;
  logic              noc_stall;
  logic              out_ctl;
  logic [DW-1:0]     out_data;
  logic              out_last;
  logic              to_ctl;
  logic [DW-1:0]     to_data;
  logic              dev_ctl;
  logic [DW-1:0]     dev_data;
  logic [DW-1:0]     src_data [NCH];

  always #5 clk = ~clk;

  always_comb begin
    ch_data = '0;
    for (int i = 0; i < NCH; i++) ch_data[i*DW +: DW] = src_data[i];
  end

  noc_ps_mux #(.NCH(NCH), .DW(DW), .DEPTH(DEPTH)) dut (
    .clk               (clk),
    .reset             (reset),
    .ch_valid          (ch_valid),
    .ch_ready          (ch_ready),
    .ch_data           (ch_data),
    .ch_last           (ch_last),
    .noc_stall         (noc_stall),
    .noc_from_dev_ctl  (out_ctl),
    .noc_from_dev_data (out_data),
    .noc_from_dev_last (out_last),
    .noc_to_dev_ctl    (to_ctl),
    .noc_to_dev_data   (to_data),
    .dev_ctl_out       (dev_ctl),
    .dev_data_out      (dev_data)
  );

  int checks = 0;
  int errors = 0;

  // Reference model: channel queues plus "packet in progress" bookkeeping.
  logic [DW:0]   fq [NCH][8];
  int            fsize [NCH];
  bit            acc [NCH];
  bit            busy;
  int            cur;
  int            rr;
  logic          e_ctl;
  logic [DW-1:0] e_data;
  logic          e_last;
  logic          e_dctl;
  logic [DW-1:0] e_ddata;

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    checks++;
    if (got !== exp) begin
      errors++;
      $display("FAIL %s: got 0x%0h expected 0x%0h", tag, got, exp);
    end
  endtask

  task automatic model_step();
    int c;
    if (reset) begin
      for (int i = 0; i < NCH; i++) begin
        fsize[i] = 0;
        acc[i]   = 1'b0;
      end
      busy = 1'b0; cur = 0; rr = 0;
      e_ctl = 1'b1; e_data = '0; e_last = 1'b0;
      e_dctl = 1'b1; e_ddata = '0;
      return;
    end
    e_dctl  = to_ctl;
    e_ddata = to_data;
    for (int i = 0; i < NCH; i++) acc[i] = ch_valid[i] && (fsize[i] < DEPTH);
    if (!noc_stall) begin
      if (!busy) begin
        c = -1;
        for (int k = 0; k < NCH; k++)
          if (c < 0 && fsize[(rr + k) % NCH] > 0) c = (rr + k) % NCH;
        e_ctl = 1'b1; e_last = 1'b0; e_data = '0;
        if (c >= 0) begin
          busy   = 1'b1;
          cur    = c;
          e_data = 8'h80 | 8'(c);
        end
      end else if (e_last) begin
        busy = 1'b0;
        rr   = (cur + 1) % NCH;
        e_ctl = 1'b1; e_data = '0; e_last = 1'b0;
      end else if (fsize[cur] > 0) begin
        {e_last, e_data} = fq[cur][0];
        e_ctl = 1'b0;
        for (int k = 0; k < 7; k++) fq[cur][k] = fq[cur][k+1];
        fsize[cur]--;
      end else begin
        e_ctl = 1'b1; e_data = '0; e_last = 1'b0;
      end
    end
    for (int i = 0; i < NCH; i++) begin
      if (acc[i]) begin
        fq[i][fsize[i]] = {ch_last[i], src_data[i]};
        fsize[i]++;
      end
    end
  endtask

  task automatic compare_all();
    logic [NCH-1:0] er;
    for (int i = 0; i < NCH; i++) er[i] = (fsize[i] < DEPTH);
    check("ch_ready", 32'(ch_ready), 32'(er));
    check("out_ctl",  32'(out_ctl),  32'(e_ctl));
    check("out_data", 32'(out_data), 32'(e_data));
    check("out_last", 32'(out_last), 32'(e_last));
    check("dev_ctl",  32'(dev_ctl),  32'(e_dctl));
    check("dev_data", 32'(dev_data), 32'(e_ddata));
  endtask

  task automatic tick();
    model_step();
    @(posedge clk);
    @(negedge clk);
    for (int i = 0; i < NCH; i++) if (acc[i]) ch_valid[i] = 1'b0;
    compare_all();
  endtask

  task automatic put(input int ch, input logic [7:0] d, input logic l);
    ch_valid[ch] = 1'b1;
    src_data[ch] = d;
    ch_last[ch]  = l;
  endtask

  task automatic clear_in();
    ch_valid = '0;
    ch_last  = '0;
    for (int i = 0; i < NCH; i++) src_data[i] = '0;
  endtask

  function automatic logic [31:0] word();
    return 32'({out_ctl, out_last, out_data});
  endfunction

  logic [9:0] exp36 [8];

  initial begin
    reset = 1'b1; noc_stall = 1'b0; to_ctl = 1'b0; to_data = '0;
    clear_in();
    @(negedge clk);
    tick(); tick();
    check("rst_word",    word(), 32'h200);
    check("rst_ready",   32'(ch_ready), 32'hF);
    check("rst_dev_ctl", 32'(dev_ctl), 32'h1);

    // Two-flit packet on ch1: header, payloads, then idle.
    reset = 1'b0;
    put(1, 8'h11, 1'b0); tick();
    put(1, 8'h22, 1'b1); tick();
    check("p35_hdr",  word(), 32'h281); tick();
    check("p35_pl0",  word(), 32'h011); tick();
    check("p35_pl1",  word(), 32'h122); tick();
    check("p35_idle", word(), 32'h200);

    // Simultaneous packets on ch0 and ch2 are sent whole, ch0 first.
    reset = 1'b1; tick(); reset = 1'b0;
    put(0, 8'hA0, 1'b0); put(2, 8'hC0, 1'b0); tick();
    put(0, 8'hA1, 1'b1); put(2, 8'hC1, 1'b1); tick();
    exp36 = '{10'h280, 10'h0A0, 10'h1A1, 10'h200, 10'h282, 10'h0C0, 10'h1C1, 10'h200};
    for (int k = 0; k < 8; k++) begin
      check($sformatf("p36_seq%0d", k), word(), 32'(exp36[k]));
      tick();
    end
    // Round-robin pointer now at 3: ch3 wins over ch0.
    put(0, 8'h55, 1'b1); put(3, 8'h66, 1'b1); tick(); tick();
    check("p36_rr_hdr", word(), 32'h283);
    for (int k = 0; k < 12; k++) tick();

    // Ch3 fills its FIFO under stall; fifth flit waits for the first pop.
    reset = 1'b1; tick(); reset = 1'b0;
    noc_stall = 1'b1;
    for (int p = 0; p < 4; p++) begin
      put(3, 8'(8'h30 + p), 1'b0); tick();
    end
    check("p37_full", 32'(ch_ready), 32'h7);
    put(3, 8'h34, 1'b1); tick(); tick();
    check("p37_still_full", 32'(ch_ready[3]), 32'h0);
    noc_stall = 1'b0;
    for (int k = 0; k < 14; k++) tick();

    // Three-cycle stall in the middle of a ch1 packet.
    put(1, 8'h91, 1'b0); tick();
    put(1, 8'h92, 1'b0); tick();
    put(1, 8'h93, 1'b1); tick();
    noc_stall = 1'b1; tick(); tick(); tick();
    noc_stall = 1'b0;
    for (int k = 0; k < 8; k++) tick();

    // Late flit on ch0 produces bubbles while ch2 waits.
    reset = 1'b1; tick(); reset = 1'b0;
    put(0, 8'hD1, 1'b0); put(2, 8'hE1, 1'b1);
    tick(); tick(); tick(); tick();
    check("p39_bubble0", word(), 32'h200);
    put(0, 8'hD2, 1'b1); tick();
    check("p39_bubble1", word(), 32'h200); tick();
    check("p39_late",    word(), 32'h1D2); tick(); tick();
    check("p39_ch2_hdr", word(), 32'h282);
    for (int k = 0; k < 6; k++) tick();

    // Reset in the middle of a packet discards buffered flits.
    put(1, 8'hB0, 1'b0); tick();
    put(1, 8'hB1, 1'b0); tick();
    clear_in(); tick();
    reset = 1'b1; to_ctl = 1'b0; tick();
    check("p40_idle",    word(), 32'h200);
    check("p40_ready",   32'(ch_ready), 32'hF);
    check("p40_dev_ctl", 32'(dev_ctl), 32'h1);
    reset = 1'b0; to_data = 8'h5A; tick();
    check("p40_dev_data", 32'(dev_data), 32'h5A);
    check("p40_after",    word(), 32'h200);

    // Randomized traffic with stalls, inbound data and occasional resets.
    for (int n = 0; n < 3000; n++) begin
      for (int i = 0; i < NCH; i++)
        if (!ch_valid[i] && $urandom_range(0, 2) == 0)
          put(i, 8'($urandom), $urandom_range(0, 2) == 0);
      noc_stall = ($urandom_range(0, 3) == 0);
      to_ctl    = 1'($urandom_range(0, 1));
      to_data   = 8'($urandom);
      reset     = ($urandom_range(0, 299) == 0);
      tick();
    end

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule

// File: doc/noc_ps_mux.md
NOC_PS_MUX -- requirements
Module: noc_ps_mux

Interface
REQ-001 The block SHALL have parameter NCH, default 4, meaning the number of device channels (legal range 2..8).
REQ-002 The block SHALL have parameter DW, default 8, meaning the data width of the NoC and the channels, with DW >= $clog2(NCH)+1.
REQ-003 The block SHALL have parameter DEPTH, default 4, meaning the entries per channel FIFO (power of 2, at least 2).
REQ-004 clk  in  1  sole clock; all state SHALL update on its rising edge.
REQ-005 reset  in  1  synchronous, active-high reset.
REQ-006 ch_valid  in  NCH  per-channel flit valid.
REQ-007 ch_ready  out  NCH  per-channel FIFO not full.
REQ-008 ch_data  in  NCH*DW  per-channel flit; channel i occupies bits [i*DW +: DW].
REQ-009 ch_last  in  NCH  per-channel last-flit-of-packet flag.
REQ-010 noc_stall  in  1  NoC backpressure; 1 means hold the output.
REQ-011 noc_from_dev_ctl  out  1  1 = control flit, 0 = payload flit.
REQ-012 noc_from_dev_data  out  DW  output flit.
REQ-013 noc_from_dev_last  out  1  marks the final payload flit of a packet.
REQ-014 noc_to_dev_ctl  in  1  inbound NoC control bit.
REQ-015 noc_to_dev_data  in  DW  inbound NoC data.
REQ-016 dev_ctl_out  out  1  registered copy of noc_to_dev_ctl.
REQ-017 dev_data_out  out  DW  registered copy of noc_to_dev_data.

Function
REQ-018 Each channel SHALL have a FIFO of DEPTH entries, each holding {last, data}; a push SHALL occur on ch_valid[i] && ch_ready[i].
REQ-019 ch_ready[i] SHALL equal !full[i], based on the registered count, so it does not depend combinationally on pops.
REQ-020 A push and a pop in the same cycle on a non-full, non-empty FIFO SHALL leave the count unchanged, and the read/write pointers SHALL wrap modulo DEPTH.
REQ-021 Flit encodings on the output:
- Idle flit: ctl=1, data=0.
- Header flit: ctl=1, data MSB=1, data[$clog2(NCH)-1:0]=granted channel, all other bits 0.
- Payload flit: ctl=0.
REQ-022 The FSM SHALL have states IDLE, HDR and BODY, and all outputs SHALL be registered.
REQ-023 In IDLE, if any FIFO is non-empty, the FSM SHALL grant the first non-empty channel at or after rr_ptr (round-robin), load the header into the output register, and go to HDR; otherwise it SHALL drive idle.
REQ-024 In HDR, with noc_stall=0, the FSM SHALL go to BODY and pop the granted FIFO into the output register if it is non-empty; otherwise it SHALL output an idle flit (bubble).
REQ-025 In BODY, with noc_stall=0, each cycle SHALL pop and emit the next flit of the granted FIFO, or emit a bubble if that FIFO is empty.
REQ-026 Arbitration SHALL be packet-atomic: no other channel is granted until the flit with last=1 has been emitted.
REQ-027 In BODY, the flit with last=1 SHALL be emitted with noc_from_dev_last=1.
REQ-028 After the flit with last=1 is accepted (noc_stall=0), the FSM SHALL set rr_ptr to (granted+1) mod NCH and return to IDLE.
REQ-029 While noc_stall=1, all outputs SHALL hold, no pop SHALL occur, the FSM SHALL not change state, and pushes SHALL continue.
REQ-030 Latency: a flit pushed in cycle t into an empty block SHALL produce a header visible at t+2 and its payload visible at t+3 (with no stall).
REQ-031 A single-flit packet (last=1 on the first flit) SHALL produce a header followed by one payload flit with noc_from_dev_last=1.
REQ-032 dev_ctl_out and dev_data_out SHALL equal noc_to_dev_ctl and noc_to_dev_data delayed by exactly one cycle, independent of noc_stall.

Reset
REQ-033 While reset=1 at a clock edge:
- FIFOs empty, ch_ready all 1.
- FSM in IDLE, rr_ptr=0.
- noc_from_dev_ctl=1, noc_from_dev_data=0, noc_from_dev_last=0.
- dev_ctl_out=1, dev_data_out=0.
REQ-034 Reset asserted mid-packet SHALL discard all buffered flits; the first cycle after reset SHALL output an idle flit.

Verification
REQ-035 NCH=4, DW=8: ch1 pushes 0x11, 0x22(last) at t=0,1 -> t=2 ctl=1 data=0x81; t=3 ctl=0 data=0x11; t=4 ctl=0 data=0x22 with last=1; t=5 idle.
REQ-036 Channels 0 and 2 each push a 2-flit packet in the same cycle -> ch0's packet is sent completely, then ch2's packet (header 0x82), then rr_ptr=3.
REQ-037 Ch3 pushes 5 flits with no stall and the output stalled -> ch_ready[3]=0 after 4 pushes; the 5th flit is held by the sender and accepted once the first pop frees an entry.
REQ-038 noc_stall=1 for 3 cycles mid-packet -> the output flit holds for 3 cycles; the payload sequence is unchanged and no flits are lost or duplicated.
REQ-039 Ch0 sends header + 1 flit, then its next flit arrives 2 cycles late -> a bubble (ctl=1, data=0) is emitted between the flits, and no other channel is granted meanwhile.
REQ-040 Reset is pulsed during BODY -> the cycle after reset shows idle output, ch_ready=4'b1111, and dev_ctl_out=1; noc_to_dev_data=0x5A applied after reset appears on dev_data_out one cycle later.
